// File: rtl/frame_writer_pkg.sv
// Shared definitions for the frame writer: FSM state encodings and the
// layout of the 9-bit capture-FIFO word {sof, pixel[7:0]}.
package frame_writer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SYNC = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int SOF_BIT = 8;
  localparam int WORD_W  = 9;
  localparam int PIXEL_W = 8;

  // Start-of-frame marker carried in the top bit of a FIFO word.
  function automatic logic is_sof(input logic [WORD_W-1:0] word);
    return word[SOF_BIT];
  endfunction

endpackage

// File: rtl/fw_addr_ctr.sv
// Up-counter with load-to-1 and increment, plus a flag asserted while the
// count equals LAST. Loading while incrementing yields 2, which lets the
// issue counter account for a pop made in the same cycle as a realign.
module fw_addr_ctr
  import frame_writer_pkg::*;
#(
  parameter int W    = 15,
  parameter int LAST = 19199
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load1,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         at_last
);

  localparam logic [W-1:0] LAST_V = W'(LAST);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load has priority over a plain increment.
  always_comb begin
    cnt_d = cnt_q;
    if (load1) begin
      cnt_d = inc ? W'(2) : W'(1);
    end else if (inc) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign at_last = (cnt_q == LAST_V);

endmodule

// File: rtl/frame_writer.sv
// Drains the camera capture FIFO into a frame-buffer RAM at linear
// addresses 0..PIX-1, realigning on start-of-frame and flagging short
// frames. Requires PIX = H_RES*V_RES >= 2.
// Optional statistics counters are built when FW_STATS_EN is defined;
// otherwise frame_cnt and err_cnt are tied to zero.
module frame_writer
  import frame_writer_pkg::*;
#(
  parameter int H_RES  = 160,
  parameter int V_RES  = 120,
  parameter int ADDR_W = 15
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              capture_en,
  input  logic              fifo_empty,
  input  logic [8:0]        fifo_dout,
  output logic              fifo_rd,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_data,
  output logic              frame_done,
  output logic              frame_err,
  output logic              busy,
  output logic [15:0]       frame_cnt,
  output logic [7:0]        err_cnt
);

  localparam int PIX   = H_RES * V_RES;
  // The issue counter must reach PIX itself, which may need one more bit
  // than the address when PIX == 2**ADDR_W.
  localparam int ISS_W = ADDR_W + 1;

  logic [1:0]         state_q, state_d;
  logic               rd_q;
  logic               fb_we_q, fb_we_d;
  logic [ADDR_W-1:0]  fb_addr_q, fb_addr_d;
  logic [7:0]         fb_data_q, fb_data_d;
  logic               frame_done_q, frame_done_d;
  logic               frame_err_q, frame_err_d;

  logic               addr_load, addr_inc, addr_last;
  logic [ADDR_W-1:0]  addr_cnt;
  logic               iss_load, iss_inc, iss_full;
  // Only the "all pixels issued" flag of the issue counter is needed.
  logic [ISS_W-1:0]   iss_cnt_unused;

  logic               word_sof;

  assign word_sof = is_sof(fifo_dout);

  fw_addr_ctr #(
    .W    (ADDR_W),
    .LAST (PIX - 1)
  ) u_addr_ctr (
    .clk     (pclk),
    .reset   (reset),
    .load1   (addr_load),
    .inc     (addr_inc),
    .cnt     (addr_cnt),
    .at_last (addr_last)
  );

  fw_addr_ctr #(
    .W    (ISS_W),
    .LAST (PIX)
  ) u_iss_ctr (
    .clk     (pclk),
    .reset   (reset),
    .load1   (iss_load),
    .inc     (iss_inc),
    .cnt     (iss_cnt_unused),
    .at_last (iss_full)
  );

  // FSM next state, FIFO pop strobe and the write presented next cycle.
  always_comb begin
    state_d      = state_q;
    fifo_rd      = 1'b0;
    fb_we_d      = 1'b0;
    fb_addr_d    = fb_addr_q;
    fb_data_d    = fb_data_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    addr_load    = 1'b0;
    addr_inc     = 1'b0;
    iss_load     = 1'b0;
    iss_inc      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (capture_en) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        // One word in flight at a time so nothing is over-read past the SOF.
        fifo_rd = !fifo_empty && !rd_q;
        if (rd_q && word_sof) begin
          fb_we_d   = 1'b1;
          fb_addr_d = '0;
          fb_data_d = fifo_dout[PIXEL_W-1:0];
          addr_load = 1'b1;
          iss_load  = 1'b1;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        fifo_rd = !fifo_empty && !iss_full;
        iss_inc = fifo_rd;
        if (rd_q) begin
          fb_we_d   = 1'b1;
          fb_data_d = fifo_dout[PIXEL_W-1:0];
          if (word_sof) begin
            // Short frame: restart at pixel 0; issue count restarts from
            // this word plus any pop made this cycle.
            fb_addr_d   = '0;
            addr_load   = 1'b1;
            iss_load    = 1'b1;
            frame_err_d = 1'b1;
          end else begin
            fb_addr_d = addr_cnt;
            addr_inc  = !addr_last;
            if (addr_last) begin
              frame_done_d = 1'b1;
              state_d      = ST_DONE;
            end
          end
        end
      end
      ST_DONE: begin
        state_d = capture_en ? ST_SYNC : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, read-valid tracking and registered frame-buffer outputs.
  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rd_q         <= 1'b0;
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_data_q    <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_q         <= fifo_rd;
      fb_we_q      <= fb_we_d;
      fb_addr_q    <= fb_addr_d;
      fb_data_q    <= fb_data_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign fb_we      = fb_we_q;
  assign fb_addr    = fb_addr_q;
  assign fb_data    = fb_data_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != ST_IDLE);

`ifdef FW_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  // Completed frames wrap; short-frame count saturates.
  always_comb begin
    frame_cnt_d = frame_cnt_q + 16'(frame_done_q);
    err_cnt_d   = err_cnt_q;
    if (frame_err_q && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  // Statistics registers.
  always_ff @(posedge pclk) begin
    if (reset) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`else
  assign frame_cnt = '0;
  assign err_cnt   = '0;
`endif

endmodule
